// File: rtl/sdp_ram_pipe.sv
// sdp_ram_pipe: single-clock simple dual-port RAM with byte-lane write enables,
// a 1- or 2-stage read pipeline, read-during-write forwarding and a post-reset
// clear sequencer that zeroes the array before the block reports ready.
module sdp_ram_pipe #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned READ_MODE  = 1,
    parameter int unsigned BYPASS     = 1,
    parameter int unsigned INIT_CLEAR = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  ready,
    input  logic                  wrea,
    input  logic [ADDR_W-1:0]     ada,
    input  logic [DATA_W-1:0]     din,
    input  logic [DATA_W/8-1:0]   bea,
    input  logic                  ceb,
    input  logic [ADDR_W-1:0]     adb,
    input  logic                  oce,
    output logic [DATA_W-1:0]     dout,
    output logic                  dout_valid
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    localparam state_t RST_STATE = (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;
    logic              ready_nxt;
    logic              clr_we;

    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] rd_word;

    logic [DATA_W-1:0] rd1_data;
    logic              rd1_valid;

    // Accesses are only honoured once the block reports ready.
    assign wr_en = ready & wrea;
    assign rd_en = ready & ceb;

    // Sequencer state, clear counter and ready flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RST_STATE;
            cnt   <= '0;
            ready <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ready <= ready_nxt;
        end
    end

    // Next-state logic: sweep every address once, then run.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ready_nxt = ready;
        clr_we    = 1'b0;
        case (state)
            ST_INIT: begin
                clr_we  = 1'b1;
                cnt_nxt = cnt + ADDR_W'(1);
                if (cnt == '1) begin
                    state_nxt = ST_RUN;
                    ready_nxt = 1'b1;
                end
            end
            ST_RUN: begin
                ready_nxt = 1'b1;
            end
            default: begin
                state_nxt = RST_STATE;
            end
        endcase
    end

    // Array update: clear sweep or byte-lane merged write. Reset itself leaves
    // the contents alone, so writes are merely suppressed while it is held.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (clr_we) begin
                mem[cnt] <= '0;
            end else if (wr_en) begin
                for (int unsigned i = 0; i < BE_W; i++) begin
                    if (bea[i]) begin
                        mem[ada][8*i +: 8] <= din[8*i +: 8];
                    end
                end
            end
        end
    end

    // Read word, with enabled lanes of a same-address write forwarded if asked.
    always_comb begin
        rd_word = mem[adb];
        if ((BYPASS != 0) && wr_en && (ada == adb)) begin
            for (int unsigned i = 0; i < BE_W; i++) begin
                if (bea[i]) begin
                    rd_word[8*i +: 8] = din[8*i +: 8];
                end
            end
        end
    end

    // Read stage 1: capture on request, hold data otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd1_data  <= '0;
            rd1_valid <= 1'b0;
        end else begin
            rd1_valid <= rd_en;
            if (rd_en) begin
                rd1_data <= rd_word;
            end
        end
    end

    generate
        if (READ_MODE == 0) begin : g_mode0
            assign dout       = rd1_data;
            assign dout_valid = rd1_valid;
        end else begin : g_mode1
            // Output register: transfers stage 1 only when oce is high; stage 1
            // keeps advancing, so an untransferred read is simply overwritten.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    dout       <= '0;
                    dout_valid <= 1'b0;
                end else if (oce) begin
                    dout       <= rd1_data;
                    dout_valid <= rd1_valid;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_sdp_ram_pipe.sv
// Directed testbench for sdp_ram_pipe. Three instances share one stimulus:
// dut  - defaults (2-stage read, bypass, clear sweep)
// dut0 - 1-stage read, no bypass, clear sweep
// dut2 - 2-stage read, bypass, no clear sweep
module tb_sdp_ram_pipe;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 8;
    localparam int BE_W   = DATA_W / 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              wrea;
    logic [ADDR_W-1:0] ada;
    logic [DATA_W-1:0] din;
    logic [BE_W-1:0]   bea;
    logic              ceb;
    logic [ADDR_W-1:0] adb;
    logic              oce;

    logic              ready, ready0, ready2;
    logic [DATA_W-1:0] dout, dout0, dout2;
    logic              dout_valid, dv0, dv2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sdp_ram_pipe #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .READ_MODE(1), .BYPASS(1), .INIT_CLEAR(1)
    ) dut (
        .clk(clk), .reset(reset), .ready(ready), .wrea(wrea), .ada(ada), .din(din),
        .bea(bea), .ceb(ceb), .adb(adb), .oce(oce), .dout(dout), .dout_valid(dout_valid)
    );

    sdp_ram_pipe #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .READ_MODE(0), .BYPASS(0), .INIT_CLEAR(1)
    ) dut0 (
        .clk(clk), .reset(reset), .ready(ready0), .wrea(wrea), .ada(ada), .din(din),
        .bea(bea), .ceb(ceb), .adb(adb), .oce(oce), .dout(dout0), .dout_valid(dv0)
    );

    sdp_ram_pipe #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .READ_MODE(1), .BYPASS(1), .INIT_CLEAR(0)
    ) dut2 (
        .clk(clk), .reset(reset), .ready(ready2), .wrea(wrea), .ada(ada), .din(din),
        .bea(bea), .ceb(ceb), .adb(adb), .oce(oce), .dout(dout2), .dout_valid(dv2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                      input logic [BE_W-1:0] be);
        wrea = 1'b1;
        ada  = a;
        din  = d;
        bea  = be;
        tick();
        wrea = 1'b0;
        bea  = '0;
    endtask

    task automatic test_reset();
        int edges;
        logic seen_valid;
        reset = 1'b1;
        wrea = 1'b0; ada = '0; din = '0; bea = '0;
        ceb = 1'b0; adb = '0; oce = 1'b1;
        tick();
        tick();
        tests++;
        if ({ready, dout_valid, dout} !== {1'b0, 1'b0, 32'h0}) begin
            fails++;
            $display("FAIL reset_state: got ready=%b valid=%b dout=%h, expected 0 0 00000000",
                     ready, dout_valid, dout);
        end
        tests++;
        if ({ready0, dv0, dout0, ready2} !== {1'b0, 1'b0, 32'h0, 1'b0}) begin
            fails++;
            $display("FAIL reset_state_others: got ready0=%b dv0=%b dout0=%h ready2=%b, expected 0 0 00000000 0",
                     ready0, dv0, dout0, ready2);
        end
        reset = 1'b0;
        edges = 0;
        seen_valid = 1'b0;
        while (!ready && edges < 400) begin
            tick();
            edges++;
            if (edges == 1) begin
                tests++;
                if ({ready2, ready} !== 2'b10) begin
                    fails++;
                    $display("FAIL noclear_ready: got ready2=%b ready=%b after first edge, expected 1 0",
                             ready2, ready);
                end
            end
            if (edges == 50) begin
                // gated access attempt mid-sweep
                wrea = 1'b1; ada = 8'h20; din = 32'hDEADBEEF; bea = 4'hF;
                ceb  = 1'b1; adb = 8'h20;
            end
            if (edges == 51) begin
                wrea = 1'b0; bea = '0; ceb = 1'b0;
            end
            if (dout_valid || dv0) seen_valid = 1'b1;
        end
        tests++;
        if (edges !== 256) begin
            fails++;
            $display("FAIL ready_latency: got %0d edges, expected 256", edges);
        end
        tests++;
        if (ready0 !== 1'b1) begin
            fails++;
            $display("FAIL ready_latency_mode0: got ready0=%b, expected 1", ready0);
        end
        tests++;
        if (seen_valid !== 1'b0) begin
            fails++;
            $display("FAIL gated_read: got dout_valid pulse during sweep, expected none");
        end
    endtask

    task automatic test_sweep_read();
        for (int a = 0; a < 256; a++) begin
            ceb = 1'b1; adb = ADDR_W'(a); oce = 1'b1;
            tick();
            ceb = 1'b0;
            tests++;
            if ({dv0, dout0} !== {1'b1, 32'h0}) begin
                fails++;
                $display("FAIL clear_mode0[%0h]: got valid=%b dout=%h, expected 1 00000000", a, dv0, dout0);
            end
            tick();
            tests++;
            if ({dout_valid, dout} !== {1'b1, 32'h0}) begin
                fails++;
                $display("FAIL clear_mode1[%0h]: got valid=%b dout=%h, expected 1 00000000",
                         a, dout_valid, dout);
            end
            if (a == 32'h20) begin
                tests++;
                if ({dv2, dout2} !== {1'b1, 32'hDEADBEEF}) begin
                    fails++;
                    $display("FAIL noclear_write_20: got valid=%b dout=%h, expected 1 deadbeef", dv2, dout2);
                end
            end
        end
    endtask

    task automatic test_byte_enable();
        wr(8'h05, 32'h11223344, 4'b1111);
        wr(8'h05, 32'hAABBCCDD, 4'b0101);
        wr(8'h06, 32'hCAFEF00D, 4'b0000);
        ceb = 1'b1; adb = 8'h05; oce = 1'b1;
        tick();
        adb = 8'h06;
        tests++;
        if ({dv0, dout0} !== {1'b1, 32'h11BB33DD}) begin
            fails++;
            $display("FAIL be_merge_mode0: got valid=%b dout=%h, expected 1 11bb33dd", dv0, dout0);
        end
        tick();
        ceb = 1'b0;
        tests++;
        if ({dout_valid, dout} !== {1'b1, 32'h11BB33DD}) begin
            fails++;
            $display("FAIL be_merge_mode1: got valid=%b dout=%h, expected 1 11bb33dd", dout_valid, dout);
        end
        tests++;
        if ({dv0, dout0} !== {1'b1, 32'h0}) begin
            fails++;
            $display("FAIL be_zero_noop: got valid=%b dout=%h, expected 1 00000000", dv0, dout0);
        end
        tick();
        tests++;
        if ({dv0, dout0} !== {1'b0, 32'h0}) begin
            fails++;
            $display("FAIL valid_pulse_mode0: got valid=%b dout=%h, expected 0 00000000", dv0, dout0);
        end
        tick();
    endtask

    task automatic test_collision();
        wr(8'h10, 32'h01020304, 4'b1111);
        wrea = 1'b1; ada = 8'h10; din = 32'hFFFFFFFF; bea = 4'b0011;
        ceb  = 1'b1; adb = 8'h10; oce = 1'b1;
        tick();
        wrea = 1'b0; bea = '0;
        tests++;
        if ({dv0, dout0} !== {1'b1, 32'h01020304}) begin
            fails++;
            $display("FAIL collision_nobypass: got valid=%b dout=%h, expected 1 01020304", dv0, dout0);
        end
        tick();
        ceb = 1'b0;
        tests++;
        if ({dout_valid, dout} !== {1'b1, 32'h0102FFFF}) begin
            fails++;
            $display("FAIL collision_bypass: got valid=%b dout=%h, expected 1 0102ffff", dout_valid, dout);
        end
        tests++;
        if ({dv0, dout0} !== {1'b1, 32'h0102FFFF}) begin
            fails++;
            $display("FAIL collision_next_mode0: got valid=%b dout=%h, expected 1 0102ffff", dv0, dout0);
        end
        tick();
        tests++;
        if ({dout_valid, dout} !== {1'b1, 32'h0102FFFF}) begin
            fails++;
            $display("FAIL collision_next_mode1: got valid=%b dout=%h, expected 1 0102ffff", dout_valid, dout);
        end
        tick();
        tests++;
        if ({dout_valid, dv0} !== 2'b00) begin
            fails++;
            $display("FAIL collision_idle: got valid=%b valid0=%b, expected 0 0", dout_valid, dv0);
        end
    endtask

    task automatic test_read_mode1();
        wr(8'h01, 32'h0000000A, 4'b1111);
        wr(8'h02, 32'h0000000B, 4'b1111);
        ceb = 1'b1; adb = 8'h01; oce = 1'b1;
        tick();
        adb = 8'h02;
        tests++;
        if (dout_valid !== 1'b0) begin
            fails++;
            $display("FAIL mode1_latency: got valid=%b one edge after request, expected 0", dout_valid);
        end
        tick();
        ceb = 1'b0;
        tests++;
        if ({dout_valid, dout} !== {1'b1, 32'h0000000A}) begin
            fails++;
            $display("FAIL mode1_first: got valid=%b dout=%h, expected 1 0000000a", dout_valid, dout);
        end
        tick();
        tests++;
        if ({dout_valid, dout} !== {1'b1, 32'h0000000B}) begin
            fails++;
            $display("FAIL mode1_second: got valid=%b dout=%h, expected 1 0000000b", dout_valid, dout);
        end
        tick();
        tests++;
        if ({dout_valid, dout} !== {1'b0, 32'h0000000B}) begin
            fails++;
            $display("FAIL mode1_idle_hold: got valid=%b dout=%h, expected 0 0000000b", dout_valid, dout);
        end
        // establish a distinct prior output value
        ceb = 1'b1; adb = 8'h05;
        tick();
        ceb = 1'b0;
        tick();
        tick();
        ceb = 1'b1; adb = 8'h01; oce = 1'b1;
        tick();
        adb = 8'h02; oce = 1'b0;
        tick();
        ceb = 1'b0; oce = 1'b1;
        tests++;
        if ({dout_valid, dout} !== {1'b0, 32'h11BB33DD}) begin
            fails++;
            $display("FAIL oce_hold: got valid=%b dout=%h, expected 0 11bb33dd", dout_valid, dout);
        end
        tick();
        tests++;
        if ({dout_valid, dout} !== {1'b1, 32'h0000000B}) begin
            fails++;
            $display("FAIL oce_overwrite: got valid=%b dout=%h, expected 1 0000000b", dout_valid, dout);
        end
        tick();
        tests++;
        if (dout_valid !== 1'b0) begin
            fails++;
            $display("FAIL oce_idle: got valid=%b, expected 0", dout_valid);
        end
    endtask

    task automatic test_reset_mid();
        int edges;
        logic seen_valid;
        // in-flight read interrupted by reset
        ceb = 1'b1; adb = 8'h02; oce = 1'b1;
        tick();
        ceb = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        tests++;
        if ({ready, dout_valid, dout} !== {1'b0, 1'b0, 32'h0}) begin
            fails++;
            $display("FAIL async_reset_run: got ready=%b valid=%b dout=%h, expected 0 0 00000000",
                     ready, dout_valid, dout);
        end
        tests++;
        if ({dv0, dout0} !== {1'b0, 32'h0}) begin
            fails++;
            $display("FAIL async_reset_mode0: got valid=%b dout=%h, expected 0 00000000", dv0, dout0);
        end
        tick();
        tick();
        reset = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (dout_valid || dv0) seen_valid = 1'b1;
        end
        #2;
        reset = 1'b1;
        #1;
        tests++;
        if ({ready, dout_valid} !== 2'b00) begin
            fails++;
            $display("FAIL reset_mid_sweep: got ready=%b valid=%b, expected 0 0", ready, dout_valid);
        end
        tick();
        tick();
        reset = 1'b0;
        edges = 0;
        while (!ready && edges < 400) begin
            tick();
            edges++;
            if (dout_valid || dv0) seen_valid = 1'b1;
        end
        tests++;
        if (edges !== 256) begin
            fails++;
            $display("FAIL restart_latency: got %0d edges, expected 256", edges);
        end
        tests++;
        if (seen_valid !== 1'b0) begin
            fails++;
            $display("FAIL inflight_after_reset: got a dout_valid pulse, expected none");
        end
    endtask

    task automatic test_after_restart();
        ceb = 1'b1; adb = 8'h05; oce = 1'b1;
        tick();
        adb = 8'h20;
        tick();
        ceb = 1'b0;
        tests++;
        if ({dout_valid, dout} !== {1'b1, 32'h0}) begin
            fails++;
            $display("FAIL reclear_05: got valid=%b dout=%h, expected 1 00000000", dout_valid, dout);
        end
        tick();
        tests++;
        if ({dv2, dout2} !== {1'b1, 32'hDEADBEEF}) begin
            fails++;
            $display("FAIL reset_keeps_array: got valid=%b dout=%h, expected 1 deadbeef", dv2, dout2);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sweep_read();
        test_byte_enable();
        test_collision();
        test_read_mode1();
        test_reset_mid();
        test_after_restart();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sdp_ram_pipe.md
# sdp_ram_pipe

Parametrised single-clock simple dual-port block RAM with one write port and one read port. It adds byte-lane write enables, a selectable 1- or 2-stage read pipeline with output-register enable, and read-during-write forwarding. A post-reset clear sequencer zeroes the array before the block reports ready. It serves as the generic line/feature buffer for the tracker datapath in place of fixed-geometry RAM primitives.

## Interface

- DATA_W, 32, data width in bits; must be a multiple of 8. Byte lanes BE_W = DATA_W/8.
- ADDR_W, 8, address width; DEPTH = 2**ADDR_W words.
- READ_MODE, 1, 0 = 1-cycle registered read; 1 = 2-cycle pipelined read with output register gated by oce.
- BYPASS, 1, 1 = same-cycle same-address read returns merged new data; 0 = returns old data.
- INIT_CLEAR, 1, 1 = zero the whole array after reset; 0 = skip clear.

Ports:

- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high.
- ready  out  1  high when accesses are accepted.
- wrea  in  1  write request.
- ada  in  ADDR_W  write address.
- din  in  DATA_W  write data.
- bea  in  BE_W  byte-lane enables; bea[i] covers din[8i+7:8i].
- ceb  in  1  read request.
- adb  in  ADDR_W  read address.
- oce  in  1  output register enable; used only when READ_MODE=1.
- dout  out  DATA_W  read data.
- dout_valid  out  1  dout holds data for a completed read.

## Operation

- **States.**
  - INIT: clear sweep. Entered on reset when INIT_CLEAR=1.
  - RUN: normal access.
  - With INIT_CLEAR=0, the block enters RUN directly.
- **INIT.**
  - An ADDR_W-bit counter starts at 0.
  - Each edge writes 0 to mem[cnt] and increments cnt.
  - On the edge that writes DEPTH-1: state becomes RUN and ready becomes 1.
- **Access gating.** wrea and ceb are ignored while ready=0: no array update and no read issued.
- **Write (RUN, wrea=1).**
  - For each i with bea[i]=1, the byte lane i of mem[ada] takes din lane i.
  - Other lanes are unchanged.
  - bea=0 results in a no-op.
- **Read (RUN, ceb=1).**
  - Stage 1 registers rd1_data and rd1_valid=1.
  - With ceb=0, rd1_valid=0 and rd1_data holds.
- **Collision (wrea & ceb & ada==adb, same edge).**
  - BYPASS=1: each enabled lane returns din; other lanes return the old value.
  - BYPASS=0: returns the pre-write word.
  - A write at edge N followed by a read of the same address at edge N+1 always returns the new data.
- **READ_MODE=0.** dout = rd1_data and dout_valid = rd1_valid; oce is ignored.
- **READ_MODE=1.**
  - The output register loads {dout, dout_valid} from stage 1 only on edges with oce=1.
  - With oce=0, the output holds.
  - Stage 1 advances every edge regardless of oce. There is no backpressure: a read not transferred while oce=0 is overwritten.
- **dout when idle.** dout retains its last value when dout_valid=0. Only dout_valid qualifies it.
- **Reset.**
  - Reset acts asynchronously at any time, including mid-sweep and mid-read.
  - Reset values: ready=0, dout=0, dout_valid=0, rd1_valid=0, rd1_data=0, cnt=0, state INIT (or RUN if INIT_CLEAR=0).
  - Array contents are not touched by reset itself. A restarted sweep re-clears from address 0.

## Timing

- **Write.** Takes effect at the sampling edge and is visible to a read sampled on the next edge.
- **Read latency (request sampled at edge N, with READ_MODE=0).** dout/dout_valid are valid after edge N.
- **Read latency (request sampled at edge N, with READ_MODE=1).** dout/dout_valid are valid after edge N+1 if oce=1 at N+1.
- **Throughput.** One read and one write per cycle, sustained.
- **ready after reset release (INIT_CLEAR=1).** ready=1 after exactly DEPTH rising edges; the first access is accepted on edge DEPTH+1.
- **ready after reset release (INIT_CLEAR=0).** ready=1 after the first rising edge.
- **dout_valid.** It is a pulse per read, not sticky. It deasserts one stage after a cycle with no read (subject to oce in mode 1).

## Test plan

- Reset with INIT_CLEAR=1, DATA_W=32, ADDR_W=8: release reset -> ready=0 for 255 edges and 1 after edge 256; reading 0x00..0xFF returns 0x00000000 with dout_valid per read.
- Byte-enable merge:
  - write 0x11223344 to 0x05 with bea=4'b1111;
  - then write 0xAABBCCDD with bea=4'b0101;
  - read 0x05 -> 0x11BB33DD.
- Collision, starting from mem[0x10]=0x01020304:
  - same-edge write 0xFFFFFFFF with bea=4'b0011 plus read 0x10 -> 0x0102FFFF (BYPASS=1) or 0x01020304 (BYPASS=0);
  - a read of 0x10 on the next edge -> 0x0102FFFF in both cases.
- READ_MODE=1 with mem[1]=0xA, mem[2]=0xB:
  - reads 1 and 2 on consecutive edges with oce=1 -> 0xA then 0xB, each 2 cycles after its request;
  - with oce=0 for one edge during the transfer of 0xA, dout keeps its prior value and the 0xA read is lost, replaced by 0xB when oce returns.
- Gated access during INIT: write 0xDEADBEEF to 0x20 and ceb=1 at cycle 50 of the sweep -> no dout_valid pulse; after ready, read 0x20 -> 0x00000000.
- Reset mid-operation:
  - assert reset for 2 cycles at sweep count 100 -> ready, dout and dout_valid go 0 immediately; after release, ready returns only after 256 more edges;
  - assert reset during an in-flight READ_MODE=1 read -> no dout_valid pulse follows.
